pmux_stream: RTL and testbench
==============================

# pmux_stream

Parametrised, registered N-to-1 stream multiplexer; the clocked successor to the team's combinational 16-to-1 mux. It selects one of N W-bit input channels, either by an externally driven select or by internal round-robin scan, and moves data through a one-entry output register using valid/ready handshakes. It sits between multi-channel sources (e.g. per-lane samplers) and a single downstream consumer.

## Interface
- N, default 16: number of input channels, 2..64.
- W, default 1: data width per channel, 1..64.
- SW, default $clog2(N): select/channel-index width; derived, not overridden.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; one-hot or zero.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SW  channel index used when mode=0.
- out_data  output  W  registered selected data.
- out_chan  output  SW  index of the channel held in out_data.
- out_valid  output  1  output register holds data.
- out_ready  input  1  consumer accepts data.
- out_par  output  1  even parity of out_data; present only with PMUX_PARITY_EN.

## Operation
- Output register states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load = !out_valid || out_ready. The register may accept a new word in the same cycle the old one drains.
- Grant, fixed mode (mode=0):
  - If sel < N and in_valid[sel], grant = sel.
  - Otherwise no grant.
- Grant, round-robin mode (mode=1):
  - grant = first i with in_valid[i], scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - No grant if in_valid is all zero.
- in_ready[grant] = load && grant exists. All other in_ready bits are 0. in_ready is combinational from in_valid, mode, sel, out_valid, out_ready and ptr.
- Transfer on a cycle with in_valid[g] && in_ready[g]:
  - out_data ← in_data[g].
  - out_chan ← g.
  - out_valid ← 1.
- Round-robin pointer ptr (SW bits):
  - After a transfer in mode=1, ptr ← g+1; g = N-1 wraps ptr to 0.
  - ptr is unchanged on fixed-mode transfers and on idle cycles.
  - ptr is retained across mode changes.
- When out_valid && out_ready and no new transfer, out_valid ← 0. out_data and out_chan hold their last values.
- While out_valid && !out_ready:
  - out_data, out_chan and out_valid are stable.
  - All in_ready bits are 0.
- sel or mode may change on any cycle. They only affect the grant for that cycle; an already-registered word is never altered.
- sel ≥ N (possible when N is not a power of two) never grants and never causes X propagation.

## Timing
- Reset values (asynchronous on rst_n low, held until the first rising clk after release):
  - out_valid=0, out_data=0, out_chan=0, ptr=0.
  - out_par=0 when present.
- in_ready is 0 during reset.
- Latency: input transfer at edge k gives out_valid=1 with the data visible after edge k.
- Throughput: one word per cycle while out_ready is held 1 and a grant exists.
- Reset asserted mid-stream discards the held word immediately. No partial state survives reset.
- Simultaneous drain and load: the new word replaces the old one in the same edge, and out_valid stays 1.

## Configuration
- PMUX_PARITY_EN:
  - Defined: out_par port exists and is registered alongside out_data as the XOR-reduction of the loaded word, so it is valid whenever out_valid=1. Reset value is 0.
  - Undefined: the out_par port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset and idle: N=16, W=1, rst_n pulse with all in_valid=0 → out_valid=0, out_chan=0 and in_ready=0 every cycle.
- Fixed-mode sweep, the registered equivalent of the 16x1 check:
  - Stimulus: mode=0, out_ready=1, in_valid=16'hFFFF; for sel=0..15, drive in_data=j for j=0..127.
  - Response: out_data == in_data[sel] one cycle later, out_chan == sel, and in_ready == 1<<sel.
- Round-robin fairness:
  - Stimulus: N=4, W=8, mode=1, out_ready=1, in_valid=4'b1011 held.
  - Response: out_chan sequence is 0,1,3,0,1,3…; channel 2 is never granted; ptr wraps 3→0.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles after the first load of 8'hA5.
  - Response: out_data=8'hA5 and out_valid=1 are stable and in_ready=0 throughout; on out_ready=1, the next word loads in the same edge.
- Boundary select and mode switch:
  - Stimulus: N=12, mode=0, sel=13 with all valid.
  - Response: no grant and out_valid falls after draining.
  - Stimulus: then switch to mode=1 mid-stream with ptr=5.
  - Response: next grant is channel 5.
- Async reset mid-operation and parity:
  - Stimulus: with PMUX_PARITY_EN, load 8'h07.
  - Response: out_par=1.
  - Stimulus: assert rst_n low between clock edges.
  - Response: out_valid, out_data and out_par drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pmux_stream_if.sv
// Handshake/bus bundle for pmux_stream: N W-bit input channels in, one registered stream out.
// out_par exists only when PMUX_PARITY_EN is defined.
// slave = mux side, master = the surrounding source/consumer side.
interface pmux_stream_if #(
  parameter int N = 16,
  parameter int W = 1
);
  localparam int SW = $clog2(N);

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_chan;
  logic           out_valid;
  logic           out_ready;
`ifdef PMUX_PARITY_EN
  logic           out_par;
`endif

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
`ifdef PMUX_PARITY_EN
    , output out_par
`endif
  );

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
`ifdef PMUX_PARITY_EN
    , input out_par
`endif
  );
endinterface

// File: rtl/pmux_stream.sv
// Registered N-to-1 stream mux, fixed select or round-robin; optional out_par via PMUX_PARITY_EN.
// Latency: one cycle from input handshake to out_valid; one word per cycle when out_ready=1.
// Backpressure: while out_valid && !out_ready the register holds and every in_ready is 0.
module pmux_stream #(
  parameter int N = 16,
  parameter int W = 1
) (
  input logic          clk,
  input logic          rst_n,
  pmux_stream_if.slave s
);
  localparam int SW = $clog2(N);

  logic [SW-1:0] ptr;
  logic [SW-1:0] gnt;
  logic          gnt_vld;
  logic [W-1:0]  gnt_data;
  logic          load;
  logic          take;

  function automatic logic [SW-1:0] wrap_idx(input logic [SW-1:0] base, input int off);
    int t;
    t = int'(base) + off;
    if (t >= N) t = t - N;
    return SW'(t);
  endfunction

  assign load = !s.out_valid || s.out_ready;
  assign take = load && gnt_vld;

  // Fixed mode compares against every legal index, so sel >= N simply finds nothing.
  // Round-robin walks offsets downward so the smallest offset from ptr is the last write.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    if (!s.mode) begin
      for (int i = 0; i < N; i++) begin
        if (s.sel == SW'(i) && s.in_valid[i]) begin
          gnt     = SW'(i);
          gnt_vld = 1'b1;
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (s.in_valid[wrap_idx(ptr, k)]) begin
          gnt     = wrap_idx(ptr, k);
          gnt_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt == SW'(i)) gnt_data = s.in_data[i*W +: W];
    end
  end

  assign s.in_ready = (rst_n && take) ? (N'(1) << gnt) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s.out_valid <= 1'b0;
      s.out_data  <= '0;
      s.out_chan  <= '0;
      ptr         <= '0;
    end else begin
      if (take) begin
        s.out_valid <= 1'b1;
        s.out_data  <= gnt_data;
        s.out_chan  <= gnt;
        if (s.mode) ptr <= (gnt == SW'(N - 1)) ? '0 : gnt + SW'(1);
      end else if (s.out_ready) begin
        s.out_valid <= 1'b0;
      end
    end
  end

`ifdef PMUX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s.out_par <= 1'b0;
    end else if (take) begin
      s.out_par <= ^gnt_data;
    end
  end
`else
  // Without parity the output register carries only data and channel.
`endif

endmodule

// File: tb/tb_pmux_stream.sv
// Three pmux_stream instances (16x1, 4x8, 12x8) driven together and checked each cycle
// against a queue-free behavioural model of grant, register and pointer.
module tb_pmux_stream;
  localparam int NA = 16, WA = 1;
  localparam int NB = 4,  WB = 8;
  localparam int NC = 12, WC = 8;
  localparam int SWA = $clog2(NA), SWB = $clog2(NB), SWC = $clog2(NC);
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pmux_stream_if #(.N(NA), .W(WA)) ifa ();
  pmux_stream_if #(.N(NB), .W(WB)) ifb ();
  pmux_stream_if #(.N(NC), .W(WC)) ifc ();

  pmux_stream #(.N(NA), .W(WA)) dut_a (.clk(clk), .rst_n(rst_n), .s(ifa));
  pmux_stream #(.N(NB), .W(WB)) dut_b (.clk(clk), .rst_n(rst_n), .s(ifb));
  pmux_stream #(.N(NC), .W(WC)) dut_c (.clk(clk), .rst_n(rst_n), .s(ifc));

  int n_checks = 0;
  int n_errors = 0;

  int nch[ND]    = '{NA, NB, NC};
  int wid[ND]    = '{WA, WB, WC};
  int selmax[ND] = '{(1 << SWA) - 1, (1 << SWB) - 1, (1 << SWC) - 1};

  // stimulus per instance
  logic [63:0] st_v[ND];
  logic [7:0]  st_d[ND][64];
  bit          st_mode[ND];
  int          st_sel[ND];
  bit          st_ordy[ND];

  // reference model state
  bit          m_vld[ND];
  logic [7:0]  m_dat[ND];
  int          m_chan[ND];
  int          m_ptr[ND];

  // observed values
  logic [63:0] o_rdy[ND];
  logic        o_vld[ND];
  logic [7:0]  o_dat[ND];
  logic [7:0]  o_chan[ND];
  logic        o_par[ND];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_grant(input int n, input logic [63:0] v, input bit mode,
                                   input int sel, input int ptr);
    if (!mode) return (sel < n && v[sel]) ? sel : -1;
    for (int k = 0; k < n; k++) begin
      if (v[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < ND; k++) begin
      m_vld[k] = 1'b0; m_dat[k] = 8'd0; m_chan[k] = 0; m_ptr[k] = 0;
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NA; i++) ifa.in_data[i] = st_d[0][i][0];
    for (int i = 0; i < NB; i++) ifb.in_data[i*WB +: WB] = st_d[1][i];
    for (int i = 0; i < NC; i++) ifc.in_data[i*WC +: WC] = st_d[2][i];
    ifa.in_valid = st_v[0][NA-1:0]; ifa.mode = st_mode[0];
    ifa.sel = st_sel[0][SWA-1:0];   ifa.out_ready = st_ordy[0];
    ifb.in_valid = st_v[1][NB-1:0]; ifb.mode = st_mode[1];
    ifb.sel = st_sel[1][SWB-1:0];   ifb.out_ready = st_ordy[1];
    ifc.in_valid = st_v[2][NC-1:0]; ifc.mode = st_mode[2];
    ifc.sel = st_sel[2][SWC-1:0];   ifc.out_ready = st_ordy[2];
  endtask

  task automatic sample();
    o_rdy[0] = 64'(ifa.in_ready); o_vld[0] = ifa.out_valid;
    o_dat[0] = 8'(ifa.out_data);  o_chan[0] = 8'(ifa.out_chan);
    o_rdy[1] = 64'(ifb.in_ready); o_vld[1] = ifb.out_valid;
    o_dat[1] = 8'(ifb.out_data);  o_chan[1] = 8'(ifb.out_chan);
    o_rdy[2] = 64'(ifc.in_ready); o_vld[2] = ifc.out_valid;
    o_dat[2] = 8'(ifc.out_data);  o_chan[2] = 8'(ifc.out_chan);
`ifdef PMUX_PARITY_EN
    o_par[0] = ifa.out_par; o_par[1] = ifb.out_par; o_par[2] = ifc.out_par;
`else
    for (int k = 0; k < ND; k++) o_par[k] = 1'b0;
`endif
  endtask

  task automatic check_outputs();
    for (int k = 0; k < ND; k++) begin
      check($sformatf("out_valid[%0d]", k), o_vld[k], m_vld[k]);
      check($sformatf("out_data[%0d]", k), o_dat[k], m_dat[k]);
      check($sformatf("out_chan[%0d]", k), o_chan[k], m_chan[k]);
`ifdef PMUX_PARITY_EN
      check($sformatf("out_par[%0d]", k), o_par[k], ^m_dat[k]);
`endif
    end
  endtask

  task automatic rand_stim(input int k);
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: r = 64'd0;
      1: r = r & {$urandom, $urandom};
      default: ;
    endcase
    if (nch[k] < 64) r = r & ((64'd1 << nch[k]) - 64'd1);
    st_v[k] = r;
    for (int i = 0; i < 64; i++) st_d[k][i] = (wid[k] == 1) ? 8'($urandom & 1) : 8'($urandom);
    st_mode[k] = 1'($urandom_range(0, 1));
    st_sel[k]  = int'($urandom_range(0, selmax[k]));
    st_ordy[k] = ($urandom_range(0, 3) != 0);
  endtask

  // Called at a falling edge: drive, check in_ready, advance model, check registered outputs.
  task automatic cycle();
    int g;
    logic [63:0] er;
    apply();
    #1;
    sample();
    for (int k = 0; k < ND; k++) begin
      g  = ref_grant(nch[k], st_v[k], st_mode[k], st_sel[k], m_ptr[k]);
      er = ((!m_vld[k] || st_ordy[k]) && g >= 0) ? (64'd1 << g) : 64'd0;
      check($sformatf("in_ready[%0d]", k), o_rdy[k], er);
      if (g >= 0 && (!m_vld[k] || st_ordy[k])) begin
        m_dat[k]  = st_d[k][g];
        m_chan[k] = g;
        m_vld[k]  = 1'b1;
        if (st_mode[k]) m_ptr[k] = (g + 1) % nch[k];
      end else if (st_ordy[k]) begin
        m_vld[k] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    sample();
    check_outputs();
    @(negedge clk);
  endtask

  // Reset dropped between edges: outputs must clear before any clock edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    sample();
    model_reset();
    for (int k = 0; k < ND; k++) check($sformatf("rst_in_ready[%0d]", k), o_rdy[k], 64'd0);
    check_outputs();
    @(posedge clk);
    #1;
    sample();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int seq[3] = '{0, 1, 3};

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < ND; k++) begin
      rand_stim(k);
      st_v[k]    = (64'd1 << nch[k]) - 64'd1;
      st_ordy[k] = 1'b1;
    end
    apply();
    model_reset();

    // reset held with every channel valid: nothing may be offered or loaded
    repeat (2) @(negedge clk);
    #1;
    sample();
    for (int k = 0; k < ND; k++) check($sformatf("rst_in_ready[%0d]", k), o_rdy[k], 64'd0);
    check_outputs();
    @(posedge clk);
    #1;
    sample();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // idle
    for (int k = 0; k < ND; k++) st_v[k] = 64'd0;
    repeat (4) cycle();

    // fixed-mode sweep on the 16x1 instance
    st_mode[0] = 1'b0; st_ordy[0] = 1'b1; st_v[0] = 64'hFFFF;
    for (int s = 0; s < NA; s++) begin
      for (int j = 0; j < 128; j++) begin
        st_sel[0] = s;
        for (int i = 0; i < NA; i++) st_d[0][i] = 8'((j >> i) & 1);
        rand_stim(1);
        rand_stim(2);
        cycle();
      end
    end

    // round-robin fairness on the 4x8 instance from a fresh pointer
    async_reset();
    st_mode[1] = 1'b1; st_ordy[1] = 1'b1; st_v[1] = 64'b1011;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NB; i++) st_d[1][i] = 8'($urandom);
      cycle();
      check("rr_seq", o_chan[1], seq[c % 3]);
    end

    // backpressure
    st_mode[1] = 1'b0; st_sel[1] = 2; st_v[1] = 64'b0100; st_d[1][2] = 8'hA5; st_ordy[1] = 1'b1;
    cycle();
    st_ordy[1] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      st_d[1][2] = 8'($urandom);
      cycle();
      check("bp_hold_data", o_dat[1], 8'hA5);
      check("bp_hold_valid", o_vld[1], 1'b1);
    end
    st_ordy[1] = 1'b1; st_d[1][2] = 8'h3C;
    cycle();
    check("bp_reload", o_dat[1], 8'h3C);

    // out-of-range select, then mode switch with ptr=5 on the 12x8 instance
    st_mode[2] = 1'b0; st_ordy[2] = 1'b1; st_v[2] = 64'hFFF; st_sel[2] = 3;
    cycle();
    st_sel[2] = 13;
    cycle();
    check("sel13_drained", o_vld[2], 1'b0);
    cycle();
    st_mode[2] = 1'b1; st_v[2] = 64'h010;
    cycle();
    st_mode[2] = 1'b0; st_sel[2] = 13; st_v[2] = 64'hFFF;
    repeat (2) cycle();
    st_mode[2] = 1'b1;
    cycle();
    check("rr_after_switch", o_chan[2], 8'd5);

    // parity word then reset between edges
    st_mode[1] = 1'b0; st_sel[1] = 0; st_v[1] = 64'b0001; st_d[1][0] = 8'h07; st_ordy[1] = 1'b1;
    cycle();
    check("load_07", o_dat[1], 8'h07);
`ifdef PMUX_PARITY_EN
    check("par_07", o_par[1], 1'b1);
`endif
    st_ordy[1] = 1'b0;
    cycle();
    async_reset();

    // randomized traffic on all instances
    for (int c = 0; c < 2500; c++) begin
      for (int k = 0; k < ND; k++) rand_stim(k);
      cycle();
      if (c % 700 == 350) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
